// File: rtl/dcache_ctrl_if.sv
// Shared types and the bus bundle for the data-cache controller.
//   dcache_pkg      : bus command / size encodings and the LSQ packet structs
//   dcache_ctrl_if  : LSQ request/response packets plus the memory bus
//     master modport : the cache controller (drives proc2mem_*, dcache2lsq_packet)
//     slave modport  : the LSQ + memory side (drives lsq2dcache_packet, mem2proc_*)
package dcache_pkg;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_command_e;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } mem_size_e;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] value;
        logic [2:0]  mem_size;      // [1:0] byte/half/word, [2] zero-extend
        logic        is_store;
        logic        lsq_is_requesting;
    } dcache_in_packet_t;

    typedef struct packed {
        logic        completed;
        logic [31:0] value;
    } dcache_out_packet_t;
endpackage

interface dcache_ctrl_if #(
    parameter int MEM_TAG_W = 4
);
    import dcache_pkg::*;

    dcache_in_packet_t    lsq2dcache_packet;
    dcache_out_packet_t   dcache2lsq_packet;
    bus_command_e         proc2mem_command;
    logic [31:0]          proc2mem_addr;
    logic [63:0]          proc2mem_data;
    logic [1:0]           proc2mem_size;
    logic [MEM_TAG_W-1:0] mem2proc_response;
    logic [63:0]          mem2proc_data;
    logic [MEM_TAG_W-1:0] mem2proc_tag;

    modport master (
        input  lsq2dcache_packet, mem2proc_response, mem2proc_data, mem2proc_tag,
        output dcache2lsq_packet, proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
    );

    modport slave (
        output lsq2dcache_packet, mem2proc_response, mem2proc_data, mem2proc_tag,
        input  dcache2lsq_packet, proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Serves one LSQ load/store at a time; a load miss fetches the 8-byte line,
// every store goes to memory and also updates the line on a hit.
// Ports:
//   clock    : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : dcache_ctrl_if.master (LSQ packets + memory bus)
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int MEM_TAG_W = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    dcache_ctrl_if.master bus
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - 3 - IDX_W;

    typedef enum logic [2:0] {IDLE, MISS_REQ, MISS_WAIT, ST_REQ, DONE} state_e;

    state_e               state_q, state_d;
    logic [MEM_TAG_W-1:0] pend_q, pend_d;
    logic                 completed_q, completed_d;
    logic [31:0]          value_q, value_d;
    logic [NUM_LINES-1:0] valid_q;

    logic [63:0]          data_mem [NUM_LINES];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];

    dcache_in_packet_t    req;
    logic [IDX_W-1:0]     idx;
    logic [2:0]           off;
    logic [TAG_W-1:0]     req_tag;
    logic [63:0]          line_rd;
    logic                 hit;
    logic                 fill_en, merge_en;

    bus_command_e         cmd;
    logic [31:0]          mem_addr;
    logic [63:0]          mem_data;
    logic [1:0]           mem_size;

    // Pick the addressed byte/half/word out of a line and extend it.
    // Offset bits below the access alignment are dropped.
    function automatic logic [31:0] extract(input logic [63:0] line,
                                            input logic [2:0]  offs,
                                            input logic [2:0]  size);
        logic [63:0] sh;
        logic [31:0] r;
        sh = '0;
        r  = '0;
        case (size[1:0])
            2'd0: begin
                sh = line >> {offs, 3'b000};
                r  = size[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'd1: begin
                sh = line >> {offs[2:1], 4'b0000};
                r  = size[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: begin
                sh = line >> {offs[2], 5'b00000};
                r  = sh[31:0];
            end
        endcase
        return r;
    endfunction

    // Overwrite the byte/half/word lane of a line with store data.
    function automatic logic [63:0] merge(input logic [63:0] line,
                                          input logic [2:0]  offs,
                                          input logic [2:0]  size,
                                          input logic [31:0] val);
        logic [63:0] mask;
        logic [63:0] wdata;
        logic [5:0]  sh;
        case (size[1:0])
            2'd0:    begin sh = {offs, 3'b000};          mask = 64'h0000_0000_0000_00FF; end
            2'd1:    begin sh = {offs[2:1], 4'b0000};    mask = 64'h0000_0000_0000_FFFF; end
            default: begin sh = {offs[2], 5'b00000};     mask = 64'h0000_0000_FFFF_FFFF; end
        endcase
        mask  = mask << sh;
        wdata = {32'b0, val} << sh;
        return (line & ~mask) | (wdata & mask);
    endfunction

    assign req     = bus.lsq2dcache_packet;
    assign idx     = req.address[3 +: IDX_W];
    assign off     = req.address[2:0];
    assign req_tag = req.address[31 -: TAG_W];
    assign line_rd = data_mem[idx];
    assign hit     = valid_q[idx] && (tag_mem[idx] == req_tag);

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        value_d  = value_q;
        fill_en  = 1'b0;
        merge_en = 1'b0;
        cmd      = BUS_NONE;
        mem_addr = '0;
        mem_data = '0;
        mem_size = '0;
        case (state_q)
            IDLE: begin
                if (req.lsq_is_requesting) begin
                    if (req.is_store) begin
                        state_d = ST_REQ;
                    end else if (hit) begin
                        value_d = extract(line_rd, off, req.mem_size);
                        state_d = DONE;
                    end else begin
                        state_d = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                cmd      = BUS_LOAD;
                mem_addr = {req.address[31:3], 3'b000};
                mem_size = DOUBLE;
                if (bus.mem2proc_response != '0) begin
                    pend_d  = bus.mem2proc_response;
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                // A zero pending tag never matches, so idle bus cycles are not fills.
                if ((pend_q != '0) && (bus.mem2proc_tag == pend_q)) begin
                    fill_en = 1'b1;
                    value_d = extract(bus.mem2proc_data, off, req.mem_size);
                    pend_d  = '0;
                    state_d = DONE;
                end
            end
            ST_REQ: begin
                cmd      = BUS_STORE;
                mem_addr = req.address;
                mem_size = req.mem_size[1:0];
                mem_data = {32'b0, req.value};
                if (bus.mem2proc_response != '0) begin
                    merge_en = hit;       // a store miss never allocates
                    value_d  = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // completed is high during the single cycle spent in DONE.
        completed_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            completed_q <= 1'b0;
            value_q     <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            completed_q <= completed_d;
            value_q     <= value_d;
            if (fill_en) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // Line storage carries no reset; the valid bits gate every read.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            data_mem[idx] <= bus.mem2proc_data;
            tag_mem[idx]  <= req_tag;
        end else if (merge_en) begin
            data_mem[idx] <= merge(line_rd, off, req.mem_size, req.value);
        end
    end

    assign bus.dcache2lsq_packet = '{completed: completed_q, value: value_q};
    assign bus.proc2mem_command  = cmd;
    assign bus.proc2mem_addr     = mem_addr;
    assign bus.proc2mem_data     = mem_data;
    assign bus.proc2mem_size     = mem_size;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a table of load/store transactions with a
// small bus responder, plus hand-written sequences for back-to-back hits,
// a mismatching memory tag and reset during an outstanding miss.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    dcache_ctrl_if #(.MEM_TAG_W(4)) bus ();

    dcache_ctrl #(.NUM_LINES(32), .MEM_TAG_W(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        st;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wval;
        int          resp_wait;   // bus cycles with response=0 before accepting
        logic [3:0]  tag;
        int          lat;         // cycles from accept to returning the tag
        logic [63:0] mdata;
        logic [1:0]  exp_cmd;
        logic [31:0] exp_val;
        int          exp_cyc;     // request driven -> completed seen
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wval, input int resp_wait, input logic [3:0] tag,
                                input int lat, input logic [63:0] mdata, input logic [1:0] exp_cmd,
                                input logic [31:0] exp_val, input int exp_cyc);
        vec_t v;
        v.st = st; v.addr = addr; v.size = size; v.wval = wval; v.resp_wait = resp_wait;
        v.tag = tag; v.lat = lat; v.mdata = mdata; v.exp_cmd = exp_cmd;
        v.exp_val = exp_val; v.exp_cyc = exp_cyc;
        return v;
    endfunction

    task automatic set_req(input logic st, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wval, input logic rq);
        bus.lsq2dcache_packet = '{address: addr, value: wval, mem_size: size,
                                  is_store: st, lsq_is_requesting: rq};
    endtask

    task automatic apply(input vec_t v, input string name);
        int          cyc;
        int          cmd_cyc;
        int          lat_cnt;
        bit          accepted;
        bit          done;
        logic [1:0]  seen_cmd;
        logic [31:0] seen_addr;
        logic [63:0] seen_data;
        logic [1:0]  seen_size;
        logic [31:0] got_val;
        cyc = 0; cmd_cyc = 0; lat_cnt = 0; accepted = 0; done = 0;
        seen_cmd = BUS_NONE; seen_addr = '0; seen_data = '0; seen_size = '0; got_val = '0;
        @(negedge clock);
        set_req(v.st, v.addr, v.size, v.wval, 1'b1);
        while (!done && cyc < 100) begin
            @(negedge clock);
            cyc++;
            bus.mem2proc_response = '0;
            bus.mem2proc_tag      = '0;
            if (bus.dcache2lsq_packet.completed) begin
                done    = 1;
                got_val = bus.dcache2lsq_packet.value;
                bus.lsq2dcache_packet.lsq_is_requesting = 1'b0;
            end else if (bus.proc2mem_command != BUS_NONE) begin
                if (seen_cmd == BUS_NONE) begin
                    seen_cmd  = bus.proc2mem_command;
                    seen_addr = bus.proc2mem_addr;
                    seen_data = bus.proc2mem_data;
                    seen_size = bus.proc2mem_size;
                end
                if (cmd_cyc >= v.resp_wait) begin
                    bus.mem2proc_response = v.tag;
                    accepted = 1;
                    lat_cnt  = 0;
                end
                cmd_cyc++;
            end else if (accepted) begin
                lat_cnt++;
                if (lat_cnt == v.lat) begin
                    bus.mem2proc_tag  = v.tag;
                    bus.mem2proc_data = v.mdata;
                end
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: completed never seen within %0d cycles", name, cyc);
        end else begin
            check({name, " value"},   got_val, v.exp_val);
            check({name, " latency"}, cyc, v.exp_cyc);
            check({name, " bus_cmd"}, seen_cmd, v.exp_cmd);
            if (v.exp_cmd != BUS_NONE) begin
                check({name, " cmd_cycles"}, cmd_cyc, v.resp_wait + 1);
                if (v.st) begin
                    check({name, " st_addr"}, seen_addr, v.addr);
                    check({name, " st_size"}, seen_size, v.size[1:0]);
                    check({name, " st_data"}, seen_data, {32'b0, v.wval});
                end else begin
                    check({name, " ld_addr"}, seen_addr, {v.addr[31:3], 3'b000});
                    check({name, " ld_size"}, seen_size, DOUBLE);
                end
            end
            $display("txn %s: addr=%h st=%0d value=%h cycles=%0d", name, v.addr, v.st, got_val, cyc);
        end
        @(negedge clock);
        check({name, " single_pulse"}, bus.dcache2lsq_packet.completed, 1'b0);
    endtask

    initial begin
        // Transactions run in order; later entries depend on the cache state left by earlier ones.
        // Line 0x100 bytes [0..7] after the first fill: 88 77 66 55 44 33 22 11.
        vecs[0]  = mk(0, 32'h100,  3'd0, 0, 0, 4'd3, 4, 64'h1122334455667788, BUS_LOAD,  32'hFFFFFF88, 6);
        vecs[1]  = mk(0, 32'h103,  3'd4, 0, 0, 4'd0, 0, 64'h0, BUS_NONE,  32'h00000055, 1);
        vecs[2]  = mk(0, 32'h104,  3'd2, 0, 0, 4'd0, 0, 64'h0, BUS_NONE,  32'h11223344, 1);
        vecs[3]  = mk(1, 32'h102,  3'd1, 32'h0000ABCD, 2, 4'd5, 0, 64'h0, BUS_STORE, 32'h0, 4);
        vecs[4]  = mk(0, 32'h100,  3'd2, 0, 0, 4'd0, 0, 64'h0, BUS_NONE,  32'hABCD7788, 1);
        vecs[5]  = mk(0, 32'h102,  3'd1, 0, 0, 4'd0, 0, 64'h0, BUS_NONE,  32'hFFFFABCD, 1);
        vecs[6]  = mk(0, 32'h106,  3'd5, 0, 0, 4'd0, 0, 64'h0, BUS_NONE,  32'h00001122, 1);
        // 0x2000 maps to the same index as 0x100 but a different tag.
        vecs[7]  = mk(1, 32'h2000, 3'd2, 32'hDEADBEEF, 0, 4'd1, 0, 64'h0, BUS_STORE, 32'h0, 2);
        vecs[8]  = mk(0, 32'h2000, 3'd2, 0, 1, 4'd6, 2, 64'h0123456789ABCDEF, BUS_LOAD, 32'h89ABCDEF, 5);
        vecs[9]  = mk(1, 32'h2007, 3'd0, 32'h000000A5, 0, 4'd2, 0, 64'h0, BUS_STORE, 32'h0, 2);
        vecs[10] = mk(0, 32'h2007, 3'd0, 0, 0, 4'd0, 0, 64'h0, BUS_NONE,  32'hFFFFFFA5, 1);
        vecs[11] = mk(0, 32'h2006, 3'd4, 0, 0, 4'd0, 0, 64'h0, BUS_NONE,  32'h00000023, 1);
        vecs[12] = mk(0, 32'h104,  3'd2, 0, 0, 4'd4, 1, 64'hCAFEF00D12345678, BUS_LOAD, 32'hCAFEF00D, 3);
        // Half load with a misaligned low bit: that bit is ignored.
        vecs[13] = mk(0, 32'h105,  3'd1, 0, 0, 4'd0, 0, 64'h0, BUS_NONE,  32'hFFFFF00D, 1);
        vecs[14] = mk(0, 32'h100,  3'd6, 0, 0, 4'd0, 0, 64'h0, BUS_NONE,  32'h12345678, 1);

        set_req(0, 32'h0, 3'd0, 32'h0, 1'b0);
        bus.mem2proc_response = '0;
        bus.mem2proc_data     = '0;
        bus.mem2proc_tag      = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst completed", bus.dcache2lsq_packet.completed, 1'b0);
        check("rst value",     bus.dcache2lsq_packet.value, 32'h0);
        check("rst command",   bus.proc2mem_command, BUS_NONE);
        check("rst addr",      bus.proc2mem_addr, 32'h0);
        check("rst data",      bus.proc2mem_data, 64'h0);
        check("rst size",      bus.proc2mem_size, 2'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back hits: next head arrives right after completed.
        @(negedge clock);
        set_req(0, 32'h100, 3'd2, 32'h0, 1'b1);
        @(negedge clock);
        check("b2b first completed", bus.dcache2lsq_packet.completed, 1'b1);
        check("b2b first value",     bus.dcache2lsq_packet.value, 32'h12345678);
        set_req(0, 32'h104, 3'd2, 32'h0, 1'b1);
        @(negedge clock);
        check("b2b gap completed",   bus.dcache2lsq_packet.completed, 1'b0);
        check("b2b gap value held",  bus.dcache2lsq_packet.value, 32'h12345678);
        @(negedge clock);
        check("b2b second completed", bus.dcache2lsq_packet.completed, 1'b1);
        check("b2b second value",     bus.dcache2lsq_packet.value, 32'hCAFEF00D);
        check("b2b command",          bus.proc2mem_command, BUS_NONE);
        $display("txn b2b: 0x100 then 0x104 value=%h", bus.dcache2lsq_packet.value);
        bus.lsq2dcache_packet.lsq_is_requesting = 1'b0;
        @(negedge clock);
        check("b2b after", bus.dcache2lsq_packet.completed, 1'b0);

        // Foreign memory tag while a miss with tag 2 is outstanding.
        @(negedge clock);
        set_req(0, 32'h3008, 3'd2, 32'h0, 1'b1);
        @(negedge clock);
        check("tagmis cmd", bus.proc2mem_command, BUS_LOAD);
        bus.mem2proc_response = 4'd2;
        @(negedge clock);
        bus.mem2proc_response = 4'd0;
        bus.mem2proc_tag      = 4'd7;
        bus.mem2proc_data     = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clock);
        bus.mem2proc_tag = 4'd0;
        check("tagmis ignored completed", bus.dcache2lsq_packet.completed, 1'b0);
        check("tagmis ignored command",   bus.proc2mem_command, BUS_NONE);
        @(negedge clock);
        check("tagmis still waiting", bus.dcache2lsq_packet.completed, 1'b0);
        bus.mem2proc_tag  = 4'd2;
        bus.mem2proc_data = 64'h5555666677778888;
        @(negedge clock);
        bus.mem2proc_tag = 4'd0;
        check("tagmis fill completed", bus.dcache2lsq_packet.completed, 1'b1);
        check("tagmis fill value",     bus.dcache2lsq_packet.value, 32'h77778888);
        $display("txn tagmis: addr=00003008 value=%h", bus.dcache2lsq_packet.value);
        bus.lsq2dcache_packet.lsq_is_requesting = 1'b0;
        @(negedge clock);
        check("tagmis single_pulse", bus.dcache2lsq_packet.completed, 1'b0);
        apply(mk(0, 32'h300C, 3'd2, 0, 0, 4'd0, 0, 64'h0, BUS_NONE, 32'h55556666, 1), "tagmis_hit");

        // Reset while a miss is outstanding; the late tag must be ignored.
        @(negedge clock);
        set_req(0, 32'h4010, 3'd2, 32'h0, 1'b1);
        @(negedge clock);
        check("rstmid cmd", bus.proc2mem_command, BUS_LOAD);
        bus.mem2proc_response = 4'd4;
        @(negedge clock);
        bus.mem2proc_response = 4'd0;
        reset_n = 1'b0;
        bus.lsq2dcache_packet.lsq_is_requesting = 1'b0;
        #1;
        check("rstmid completed", bus.dcache2lsq_packet.completed, 1'b0);
        check("rstmid value",     bus.dcache2lsq_packet.value, 32'h0);
        check("rstmid command",   bus.proc2mem_command, BUS_NONE);
        check("rstmid addr",      bus.proc2mem_addr, 32'h0);
        check("rstmid size",      bus.proc2mem_size, 2'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        bus.mem2proc_tag  = 4'd4;
        bus.mem2proc_data = 64'h0BAD0BAD0BAD0BAD;
        @(negedge clock);
        bus.mem2proc_tag = 4'd0;
        check("rstmid stale tag", bus.dcache2lsq_packet.completed, 1'b0);
        @(negedge clock);
        check("rstmid stale tag+1", bus.dcache2lsq_packet.completed, 1'b0);
        // Line 0x100 was valid before reset; it must miss now.
        apply(mk(0, 32'h104, 3'd2, 0, 0, 4'd1, 1, 64'h0000000100000000, BUS_LOAD, 32'h00000001, 3),
              "post_reset_miss");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
